// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-PC sequencer: control opcodes, FSM states
// and a small sign-extension helper.
package pc_sequencer_pkg;

    // Opcodes in ex_instr[15:12] that the sequencer acts on
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Sequencer states; HALT and TRAP are absorbing until reset
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_TRAP = 2'd2
    } pcseq_state_e;

    // Sign-extend an 8-bit branch displacement to the 16-bit PC width
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/pc_sequencer_return_addr_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; count, empty and full are registered.
module return_addr_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [15:0] i_data,
    output logic [15:0] o_top,
    output logic        o_empty,
    output logic        o_full
);

    localparam int PW = $clog2(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_ptr;     // next free slot; top is r_ptr-1
    logic [PW:0]   r_count;
    logic          r_empty;
    logic          r_full;

    logic [PW-1:0] w_top_idx;
    logic [PW:0]   w_count_next;

    assign w_top_idx = r_ptr - PW'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = r_empty;
    assign o_full    = r_full;

    // Occupancy after this cycle's operation; saturates when full
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred
        w_count_next = r_count;
        if (i_push) begin
            if (!r_full) w_count_next = r_count + (PW+1)'(1);
        end else if (i_pop && !r_empty) begin
            w_count_next = r_count - (PW+1)'(1);
        end
    end

    // Pointer, count and registered status flags
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (i_push) begin
                r_ptr <= r_ptr + PW'(1);
            end else if (i_pop && !r_empty) begin
                r_ptr <= r_ptr - PW'(1);
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == (PW+1)'(DEPTH));
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointer and count decide what is valid
        if (rst_n && i_push) r_mem[r_ptr] <= i_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: owns the architectural PC and updates it every cycle
// from the instruction in EX (B/CALL/RET/HLT, delayed-branch semantics).
// Optional macro RAS_TRAP_EN: RAS overflow/underflow enters a sticky TRAP
// state instead of wrapping/ignoring.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [15:0] ex_instr,
    input  logic        branch,
    output logic [15:0] pc,
    output logic        redirect,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        halted,
    output logic        trap
);

    pcseq_state_e r_state;
    pcseq_state_e w_state_next;
    logic [15:0]  r_pc;
    logic [15:0]  w_pc_next;
    logic         r_redirect;
    logic         w_redirect_next;
    logic         w_push;
    logic         w_pop;
    logic [15:0]  w_ras_top;
    logic         w_ras_empty;
    logic         w_ras_full;
    logic [15:0]  w_pc_inc;

    assign w_pc_inc = r_pc + 16'd1;

    return_addr_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full)
    );

    // Next-PC mux, RAS control and state transitions
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_redirect_next = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        if (r_state == ST_RUN && !stall) begin
            w_pc_next = w_pc_inc;
            if (ex_valid) begin
                case (ex_instr[15:12])
                    OP_B: begin
                        if (branch) begin
                            w_pc_next       = r_pc + 16'd2 + sext8(ex_instr[7:0]);
                            w_redirect_next = 1'b1;
                        end
                    end
                    OP_CALL: begin
`ifdef RAS_TRAP_EN
                        if (w_ras_full) begin
                            w_pc_next    = r_pc;
                            w_state_next = ST_TRAP;
                        end else begin
                            w_push          = 1'b1;
                            w_pc_next       = {r_pc[15:12], ex_instr[11:0]};
                            w_redirect_next = 1'b1;
                        end
`else
                        w_push          = 1'b1;
                        w_pc_next       = {r_pc[15:12], ex_instr[11:0]};
                        w_redirect_next = 1'b1;
`endif
                    end
                    OP_RET: begin
                        if (!w_ras_empty) begin
                            w_pop           = 1'b1;
                            w_pc_next       = w_ras_top;
                            w_redirect_next = 1'b1;
                        end else begin
`ifdef RAS_TRAP_EN
                            w_pc_next    = r_pc;
                            w_state_next = ST_TRAP;
`endif
                        end
                    end
                    OP_HLT: begin
                        w_pc_next    = r_pc;
                        w_state_next = ST_HALT;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, PC and redirect registers; reset overrides stall and HALT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_redirect <= w_redirect_next;
        end
    end

    assign pc        = r_pc;
    assign redirect  = r_redirect;
    assign ras_empty = w_ras_empty;
    assign ras_full  = w_ras_full;
    assign halted    = (r_state == ST_HALT);
`ifdef RAS_TRAP_EN
    assign trap      = (r_state == ST_TRAP);
`else
    assign trap      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// stimulus, all compared against a queue-based behavioural model.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [15:0] RPC   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [15:0] ex_instr = '0;
    logic        branch = 1'b0;
    logic [15:0] pc;
    logic        redirect, ras_empty, ras_full, halted, trap;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_pc = RPC;
    logic [15:0] m_stack[$];
    logic        m_redirect = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_trap = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RPC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
        .ex_instr(ex_instr), .branch(branch), .pc(pc), .redirect(redirect),
        .ras_empty(ras_empty), .ras_full(ras_full), .halted(halted), .trap(trap)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one clock edge, from the rules in plain terms
    task automatic model_clock(input logic rst, input logic st, input logic v,
                               input logic [15:0] ins, input logic br);
        int off;
        m_redirect = 1'b0;
        if (!rst) begin
            m_pc = RPC; m_stack.delete(); m_halted = 1'b0; m_trap = 1'b0;
            return;
        end
        if (m_halted || m_trap || st) return;
        if (!v) begin m_pc = m_pc + 16'd1; return; end
        case (ins[15:12])
            OP_B: begin
                if (br) begin
                    off = int'($signed(ins[7:0]));
                    m_pc = 16'(int'(m_pc) + 2 + off);
                    m_redirect = 1'b1;
                end else m_pc = m_pc + 16'd1;
            end
            OP_CALL: begin
`ifdef RAS_TRAP_EN
                if (m_stack.size() == DEPTH) begin m_trap = 1'b1; return; end
`else
                if (m_stack.size() == DEPTH) void'(m_stack.pop_front());
`endif
                m_stack.push_back(m_pc + 16'd1);
                m_pc = {m_pc[15:12], ins[11:0]};
                m_redirect = 1'b1;
            end
            OP_RET: begin
                if (m_stack.size() == 0) begin
`ifdef RAS_TRAP_EN
                    m_trap = 1'b1;
`else
                    m_pc = m_pc + 16'd1;
`endif
                end else begin
                    m_pc = m_stack.pop_back();
                    m_redirect = 1'b1;
                end
            end
            OP_HLT: m_halted = 1'b1;
            default: m_pc = m_pc + 16'd1;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},        pc,                 m_pc);
        check({tag, ".redirect"},  16'(redirect),      16'(m_redirect));
        check({tag, ".ras_empty"}, 16'(ras_empty),     16'(m_stack.size() == 0));
        check({tag, ".ras_full"},  16'(ras_full),      16'(m_stack.size() == DEPTH));
        check({tag, ".halted"},    16'(halted),        16'(m_halted));
        check({tag, ".trap"},      16'(trap),          16'(m_trap));
    endtask

    // Drive one cycle of inputs at negedge, apply edge, check #1 later
    task automatic step(input string tag, input logic rst, input logic st, input logic v,
                        input logic [15:0] ins, input logic br);
        @(negedge clk);
        rst_n = rst; stall = st; ex_valid = v; ex_instr = ins; branch = br;
        @(posedge clk);
        model_clock(rst, st, v, ins, br);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op;
        int          r;

        // 1: reset then bubbles
        step("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("reset_pc_const", pc, 16'h0000);
        for (int i = 0; i < 4; i++) step("bubble", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("bubble_pc_const", pc, 16'h0004);

        // 2: advance to 0010, B -2 taken then not taken
        while (m_pc != 16'h0010) step("seq", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("b_taken", 1'b1, 1'b0, 1'b1, {OP_B, 4'h0, 8'hFE}, 1'b1);
        check("b_taken_const", pc, 16'h0010);
        check("b_taken_redir", 16'(redirect), 16'd1);
        step("b_not", 1'b1, 1'b0, 1'b1, {OP_B, 4'h0, 8'hFE}, 1'b0);
        check("b_not_const", pc, 16'h0011);

        // 3: walk forward to 1234, CALL then RET
        while (int'(m_pc) + 129 <= 'h1234) step("b_fwd", 1'b1, 1'b0, 1'b1, {OP_B, 4'h0, 8'h7F}, 1'b1);
        while (m_pc != 16'h1234) step("seq2", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("call", 1'b1, 1'b0, 1'b1, {OP_CALL, 12'h0AB}, 1'b0);
        check("call_pc_const", pc, 16'h10AB);
        step("delay", 1'b1, 1'b0, 1'b1, 16'h1000, 1'b0);
        step("ret", 1'b1, 1'b0, 1'b1, {OP_RET, 12'h000}, 1'b0);
        check("ret_pc_const", pc, 16'h1235);
        check("ret_empty_const", 16'(ras_empty), 16'd1);

        // 4: CALL held under stall for 3 cycles, one push on release
        for (int i = 0; i < 3; i++) step("call_stall", 1'b1, 1'b1, 1'b1, {OP_CALL, 12'h321}, 1'b0);
        step("call_rel", 1'b1, 1'b0, 1'b1, {OP_CALL, 12'h321}, 1'b0);
        step("ret1", 1'b1, 1'b0, 1'b1, {OP_RET, 12'h000}, 1'b0);
        // 6a: second RET finds the stack empty
        step("ret_empty", 1'b1, 1'b0, 1'b1, {OP_RET, 12'h000}, 1'b0);

        // 5: DEPTH+1 CALLs then drain
        step("rst5", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i <= DEPTH; i++) step("call_fill", 1'b1, 1'b0, 1'b1, {OP_CALL, 12'(i * 16 + 5)}, 1'b0);
        for (int i = 0; i <= DEPTH; i++) step("ret_drain", 1'b1, 1'b0, 1'b1, {OP_RET, 12'h000}, 1'b0);

        // 6: HLT, frozen PC, reset mid-halt, reset mid-stall
        step("rst6", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("pre_hlt", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("hlt", 1'b1, 1'b0, 1'b1, {OP_HLT, 12'h000}, 1'b0);
        check("hlt_const", 16'(halted), 16'd1);
        for (int i = 0; i < 3; i++) step("halted", 1'b1, 1'b0, 1'b1, {OP_CALL, 12'h777}, 1'b0);
        step("rst_hlt", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("bub", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("rst_stall", 1'b0, 1'b1, 1'b1, {OP_CALL, 12'h055}, 1'b0);

        // Random phase
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      op = 4'($urandom_range(0, 11));
            else if (r < 62) op = OP_B;
            else if (r < 80) op = OP_CALL;
            else if (r < 97) op = OP_RET;
            else             op = OP_HLT;
            ins = {op, 12'($urandom)};
            if ((m_halted || m_trap) && $urandom_range(0, 3) == 0)
                step("rnd_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            else
                step("rnd", ($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 9) != 0), ins, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
